serial_adder_n: RTL and testbench

//  Parametrised bit-serial adder/subtractor, sequential successor to the combinational fulladd cell.

---
 rtl/serial_adder_n_pkg.sv | 11 +
 rtl/serial_adder_n_fulladd.sv | 13 +
 rtl/serial_adder_n.sv | 95 +++++++++
 tb/tb_serial_adder_n.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_n_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// The state encoding is fixed at 0/1/2 so existing controllers decoding it keep working.
package serial_adder_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_n_fulladd.sv
// One-bit full adder; used unchanged as the bit-slice of the serial adder.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: latches operands on start and adds LSB-first,
// one bit per clock, through a single full-adder cell fed by a registered carry.
module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_sum;
  logic             fa_cout;

  fulladd u_fulladd (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  assign sum = res_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      cout   <= 1'b0;
      carry  <= 1'b0;
      count  <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and force the initial carry.
            state  <= ST_RUN;
            busy   <= 1'b1;
            a_sr   <= a;
            b_sr   <= sub ? ~b : b;
            carry  <= sub ? 1'b1 : cin;
            count  <= '0;
            res_sr <= '0;
            cout   <= 1'b0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
          carry  <= fa_cout;
          count  <= count + 1'b1;
          if (count == LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= fa_cout;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n: directed cases on a 4-bit instance,
// random vectors on an 8-bit instance, both checked against an arithmetic model.
module tb_serial_adder_n;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst;
  logic       start4, sub4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic       start8, sub8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic [4:0] q4[$];
  logic [8:0] q8[$];

  int n_checks = 0;
  int n_pass   = 0;

  serial_adder_n #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_adder_n #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // {cout, sum}: add is a+b+cin; subtract is a-b offset by 2^w so bit w means a >= b.
  function automatic logic [8:0] model(input int w, input int x, input int y,
                                       input bit c, input bit s);
    int r;
    r = s ? (x - y + (1 << w)) : (x + y + int'(c));
    r = r & ((1 << (w + 1)) - 1);
    return r[8:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) check("dut4 unexpected done", 1, 0);
      else check("dut4 result {busy,cout,sum}", {busy4, cout4, sum4}, {1'b0, q4.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) check("dut8 unexpected done", 1, 0);
      else check("dut8 result {busy,cout,sum}", {busy8, cout8, sum8}, {1'b0, q8.pop_front()});
    end
  end

  task automatic issue4(input logic [3:0] x, input logic [3:0] y, input bit c, input bit s);
    logic [8:0] m;
    @(negedge clk);
    a4 = x; b4 = y; cin4 = c; sub4 = s; start4 = 1'b1;
    m = model(4, int'(x), int'(y), c, s);
    q4.push_back(m[4:0]);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  // k0 = negedges already elapsed since the accepting edge; done is due at the 5th.
  task automatic wait_done4(input string name, input int k0);
    int k = k0;
    int busy_cnt = 0;
    while (!done4 && k < 20) begin
      if (busy4) busy_cnt++;
      @(negedge clk);
      k++;
    end
    check({name, " latency"}, k, 5);
    check({name, " busy cycles"}, busy_cnt, 5 - k0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] m;
    int seen;
    int k;
    rst = 1'b1;
    start4 = 1'b1; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b1; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("reset dut4 {busy,done,cout,sum}", {busy4, done4, cout4, sum4}, 0);
    check("reset dut8 {busy,done,cout,sum}", {busy8, done8, cout8, sum8}, 0);
    rst = 1'b0; start4 = 1'b0; start8 = 1'b0;
    @(negedge clk);
    check("idle after reset busy4", busy4, 0);

    issue4(4'b0101, 4'b0011, 1'b0, 1'b0); wait_done4("add 5+3", 1);
    issue4(4'b1111, 4'b0001, 1'b0, 1'b0); wait_done4("add 15+1", 1);
    issue4(4'b0000, 4'b0000, 1'b1, 1'b0); wait_done4("add 0+0+cin", 1);
    issue4(4'b0011, 4'b0101, 1'b1, 1'b1); wait_done4("sub 3-5", 1);
    issue4(4'b0101, 4'b0011, 1'b0, 1'b1); wait_done4("sub 5-3", 1);

    // Restart attempt with new operands mid-RUN must be ignored.
    issue4(4'b1001, 4'b0110, 1'b1, 1'b0);
    @(negedge clk);
    a4 = 4'b1111; b4 = 4'b1111; sub4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_done4("restart ignored", 3);

    // Reset in the second RUN cycle aborts without a done pulse.
    issue4(4'b0111, 4'b0110, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    void'(q4.pop_back());
    @(negedge clk);
    rst = 1'b0;
    check("abort dut4 {busy,done,cout,sum}", {busy4, done4, cout4, sum4}, 0);
    seen = 0;
    repeat (8) begin @(negedge clk); seen += int'(done4); end
    check("abort no done", seen, 0);

    // start held through DONE: second op accepted with no IDLE gap.
    @(negedge clk);
    a4 = 4'b1010; b4 = 4'b0111; cin4 = 1'b1; sub4 = 1'b0; start4 = 1'b1;
    m = model(4, 10, 7, 1'b1, 1'b0); q4.push_back(m[4:0]);
    k = 0;
    do begin @(negedge clk); k++; end while (!done4 && k < 20);
    check("b2b first done latency", k, 5);
    a4 = 4'b0010; b4 = 4'b1001; sub4 = 1'b1;
    m = model(4, 2, 9, 1'b0, 1'b1); q4.push_back(m[4:0]);
    @(negedge clk);
    check("b2b no idle gap busy4", busy4, 1);
    start4 = 1'b0;
    wait_done4("b2b second", 1);

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom); sub8 = 1'($urandom);
      start8 = 1'b1;
      q8.push_back(model(8, int'(a8), int'(b8), cin8, sub8));
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      k = 1;
      while (!done8 && k < 20) begin @(negedge clk); k++; end
      check("dut8 done latency", k, 9);
    end

    repeat (3) @(negedge clk);
    check("dut4 scoreboard drained", q4.size(), 0);
    check("dut8 scoreboard drained", q8.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
